// File: rtl/mesi_isc_broad_cntl_mp_if.sv
// Signal bundle between the broadcast controller, the broadcast FIFO and the per-CPU
// coherence-bus ports. The master modport is the controller side.
interface mesi_isc_broad_cntl_mp_if #(
    parameter int unsigned CPU_COUNT        = 4,
    parameter int unsigned CBUS_CMD_WIDTH   = 3,
    parameter int unsigned BROAD_TYPE_WIDTH = 2,
    parameter int unsigned BROAD_ID_WIDTH   = 5
);
    localparam int unsigned CPU_ID_WIDTH = (CPU_COUNT > 2) ? $clog2(CPU_COUNT) : 1;

    // Coherence-bus ports
    logic [CPU_COUNT-1:0]                cbus_ack_array_i;
    logic [CPU_COUNT-1:0]                cpu_enable_i;
    logic [CPU_COUNT*CBUS_CMD_WIDTH-1:0] cbus_cmd_array_o;

    // Broadcast FIFO head and pop strobe
    logic                                fifo_status_empty_i;
    logic [BROAD_TYPE_WIDTH-1:0]         broad_snoop_type_i;
    logic [CPU_ID_WIDTH-1:0]             broad_snoop_cpu_id_i;
    logic [BROAD_ID_WIDTH-1:0]           broad_snoop_id_i;
    logic                                broad_fifo_rd_o;

    // Status
    logic                                busy_o;
    logic [BROAD_ID_WIDTH-1:0]           cur_broad_id_o;
    logic                                timeout_o;
    logic                                id_err_o;

    modport master (
        input  cbus_ack_array_i,
        input  cpu_enable_i,
        input  fifo_status_empty_i,
        input  broad_snoop_type_i,
        input  broad_snoop_cpu_id_i,
        input  broad_snoop_id_i,
        output cbus_cmd_array_o,
        output broad_fifo_rd_o,
        output busy_o,
        output cur_broad_id_o,
        output timeout_o,
        output id_err_o
    );

    modport slave (
        output cbus_ack_array_i,
        output cpu_enable_i,
        output fifo_status_empty_i,
        output broad_snoop_type_i,
        output broad_snoop_cpu_id_i,
        output broad_snoop_id_i,
        input  cbus_cmd_array_o,
        input  broad_fifo_rd_o,
        input  busy_o,
        input  cur_broad_id_o,
        input  timeout_o,
        input  id_err_o
    );
endinterface

// File: rtl/mesi_isc_broad_cntl_mp.sv
// Broadcast controller: takes the head of the broadcast FIFO, snoops every other enabled
// port, then grants the initiator its access and pops the entry.
module mesi_isc_broad_cntl_mp #(
    parameter int unsigned CPU_COUNT        = 4,
    parameter int unsigned CBUS_CMD_WIDTH   = 3,
    parameter int unsigned BROAD_TYPE_WIDTH = 2,
    parameter int unsigned BROAD_ID_WIDTH   = 5,
    parameter int unsigned TIMEOUT_CYCLES   = 256
) (
    input logic                      clk,
    input logic                      rst,
    mesi_isc_broad_cntl_mp_if.master bus
);
    localparam int unsigned CPU_ID_WIDTH = (CPU_COUNT > 2) ? $clog2(CPU_COUNT) : 1;
    localparam int unsigned CNT_WIDTH    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        CNT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam int unsigned CMD_VEC_WIDTH = CPU_COUNT * CBUS_CMD_WIDTH;

    localparam logic [CBUS_CMD_WIDTH-1:0] MESI_ISC_CBUS_CMD_NOP      = CBUS_CMD_WIDTH'(0);
    localparam logic [CBUS_CMD_WIDTH-1:0] MESI_ISC_CBUS_CMD_WR_SNOOP = CBUS_CMD_WIDTH'(1);
    localparam logic [CBUS_CMD_WIDTH-1:0] MESI_ISC_CBUS_CMD_RD_SNOOP = CBUS_CMD_WIDTH'(2);
    localparam logic [CBUS_CMD_WIDTH-1:0] MESI_ISC_CBUS_CMD_EN_WR    = CBUS_CMD_WIDTH'(3);
    localparam logic [CBUS_CMD_WIDTH-1:0] MESI_ISC_CBUS_CMD_EN_RD    = CBUS_CMD_WIDTH'(4);
    localparam logic [BROAD_TYPE_WIDTH-1:0] MESI_ISC_BREQ_TYPE_WR    = BROAD_TYPE_WIDTH'(1);

    typedef enum logic [1:0] {StIdle, StSnoop, StEnAccess, StPop} state_e;

    state_e                      state_q, state_d;
    logic [CPU_COUNT-1:0]        pending_q, pending_d;
    logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
    logic [BROAD_TYPE_WIDTH-1:0] type_q, type_d;
    logic [CPU_ID_WIDTH-1:0]     cpu_q, cpu_d;
    logic [BROAD_ID_WIDTH-1:0]   id_q, id_d;
    logic [CMD_VEC_WIDTH-1:0]    cmd_q, cmd_d;
    logic                        rd_q, busy_q, timeout_q, timeout_d, id_err_q, id_err_d;

    logic                        head_valid;
    logic [CPU_COUNT-1:0]        head_init_mask;
    logic                        init_ack;

    assign head_valid = 32'(bus.broad_snoop_cpu_id_i) < CPU_COUNT;

    // Decode the head initiator and the latched initiator's ack without indexing past the
    // port vector when CPU_COUNT is not a power of two.
    always_comb begin
        head_init_mask = '0;
        init_ack       = 1'b0;
        for (int n = 0; n < CPU_COUNT; n++) begin
            if (bus.broad_snoop_cpu_id_i == CPU_ID_WIDTH'(n)) head_init_mask[n] = 1'b1;
            if (cpu_q == CPU_ID_WIDTH'(n)) init_ack = bus.cbus_ack_array_i[n];
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;
        type_d    = type_q;
        cpu_d     = cpu_q;
        id_d      = id_q;
        timeout_d = 1'b0;
        id_err_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!bus.fifo_status_empty_i) begin
                    if (head_valid) begin
                        type_d    = bus.broad_snoop_type_i;
                        cpu_d     = bus.broad_snoop_cpu_id_i;
                        id_d      = bus.broad_snoop_id_i;
                        pending_d = bus.cpu_enable_i & ~head_init_mask;
                        cnt_d     = '0;
                        state_d   = (pending_d == '0) ? StEnAccess : StSnoop;
                    end else begin
                        // Unroutable entry: drop it without touching the bus.
                        id_err_d = 1'b1;
                        state_d  = StPop;
                    end
                end
            end
            StSnoop: begin
                pending_d = pending_q & ~bus.cbus_ack_array_i;
                if (TIMEOUT_EN) cnt_d = cnt_q + CNT_WIDTH'(1);
                if (pending_d == '0) begin
                    state_d = StEnAccess;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    pending_d = '0;
                    timeout_d = 1'b1;
                    state_d   = StEnAccess;
                end
            end
            StEnAccess: begin
                if (init_ack) state_d = StPop;
            end
            StPop: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Commands are decoded from next-state values so they leave the flops with the state.
    always_comb begin
        cmd_d = '0;
        for (int n = 0; n < CPU_COUNT; n++) begin
            cmd_d[n*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] = MESI_ISC_CBUS_CMD_NOP;
            if ((state_d == StSnoop) && pending_d[n]) begin
                cmd_d[n*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] = (type_d == MESI_ISC_BREQ_TYPE_WR) ?
                    MESI_ISC_CBUS_CMD_WR_SNOOP : MESI_ISC_CBUS_CMD_RD_SNOOP;
            end else if ((state_d == StEnAccess) && (cpu_d == CPU_ID_WIDTH'(n))) begin
                cmd_d[n*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] = (type_d == MESI_ISC_BREQ_TYPE_WR) ?
                    MESI_ISC_CBUS_CMD_EN_WR : MESI_ISC_CBUS_CMD_EN_RD;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            pending_q <= '0;
            cnt_q     <= '0;
            type_q    <= '0;
            cpu_q     <= '0;
            id_q      <= '0;
            cmd_q     <= {CPU_COUNT{MESI_ISC_CBUS_CMD_NOP}};
            rd_q      <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            id_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            type_q    <= type_d;
            cpu_q     <= cpu_d;
            id_q      <= id_d;
            cmd_q     <= cmd_d;
            rd_q      <= (state_d == StPop);
            busy_q    <= (state_d != StIdle);
            timeout_q <= timeout_d;
            id_err_q  <= id_err_d;
        end
    end

    assign bus.cbus_cmd_array_o = cmd_q;
    assign bus.broad_fifo_rd_o  = rd_q;
    assign bus.busy_o           = busy_q;
    assign bus.cur_broad_id_o   = id_q;
    assign bus.timeout_o        = timeout_q;
    assign bus.id_err_o         = id_err_q;

    a_pop_single: assert property (@(posedge clk) disable iff (rst)
        bus.broad_fifo_rd_o |=> !bus.broad_fifo_rd_o);
    a_idle_quiet: assert property (@(posedge clk) disable iff (rst)
        !bus.busy_o |-> ((bus.cbus_cmd_array_o == {CPU_COUNT{MESI_ISC_CBUS_CMD_NOP}}) &&
                         !bus.broad_fifo_rd_o));
    a_timeout_grants: assert property (@(posedge clk) disable iff (rst)
        bus.timeout_o |-> (state_q == StEnAccess));
    a_id_err_pops: assert property (@(posedge clk) disable iff (rst)
        bus.id_err_o |-> bus.broad_fifo_rd_o);
endmodule

// File: tb/tb_mesi_isc_broad_cntl_mp.sv
// Randomised and directed bench for the broadcast controller; expected traces come from
// per-port ack delays turned into phase lengths.
module tb_mesi_isc_broad_cntl_mp;
    localparam int unsigned TO = 8;
    localparam logic [2:0] C_NOP = 3'd0, C_WRS = 3'd1, C_RDS = 3'd2, C_ENWR = 3'd3, C_ENRD = 3'd4;
    localparam logic [1:0] T_WR = 2'd1, T_RD = 2'd2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mesi_isc_broad_cntl_mp_if #(.CPU_COUNT(4), .CBUS_CMD_WIDTH(3), .BROAD_TYPE_WIDTH(2),
                                .BROAD_ID_WIDTH(5)) bus ();
    mesi_isc_broad_cntl_mp_if #(.CPU_COUNT(3), .CBUS_CMD_WIDTH(3), .BROAD_TYPE_WIDTH(2),
                                .BROAD_ID_WIDTH(5)) bus3 ();

    mesi_isc_broad_cntl_mp #(.CPU_COUNT(4), .CBUS_CMD_WIDTH(3), .BROAD_TYPE_WIDTH(2),
                             .BROAD_ID_WIDTH(5), .TIMEOUT_CYCLES(TO)) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    mesi_isc_broad_cntl_mp #(.CPU_COUNT(3), .CBUS_CMD_WIDTH(3), .BROAD_TYPE_WIDTH(2),
                             .BROAD_ID_WIDTH(5), .TIMEOUT_CYCLES(TO)) u_dut3 (
        .clk(clk),
        .rst(rst),
        .bus(bus3)
    );

    int passed = 0;
    int total = 0;
    int pops_seen = 0;
    int exp_pops = 0;
    int dly[4];
    bit noise = 1'b0;

    always @(posedge clk) if (bus.broad_fifo_rd_o) pops_seen++;

    // One broadcast from the IDLE cycle at the current negedge, through POP and the idle gap.
    // dly[n]: snoop cycle in which port n acks; e: EN cycles before the initiator acks.
    task automatic bcast(input logic [1:0] typ, input logic [1:0] cpu, input logic [4:0] id,
                         input logic [3:0] en, input int e);
        logic [3:0] pend;
        logic [11:0] exp_cmd;
        logic [2:0] c;
        int lmax, len, tot;
        bit to, a;
        pend = en & ~(4'b0001 << cpu);
        lmax = 0;
        for (int n = 0; n < 4; n++) if (pend[n] && dly[n] + 1 > lmax) lmax = dly[n] + 1;
        to = (lmax > int'(TO));
        len = to ? int'(TO) : lmax;
        tot = len + e + 2;
        bus.fifo_status_empty_i = 1'b0;
        bus.broad_snoop_type_i = typ;
        bus.broad_snoop_cpu_id_i = cpu;
        bus.broad_snoop_id_i = id;
        bus.cpu_enable_i = en;
        for (int n = 0; n < 4; n++) bus.cbus_ack_array_i[n] = noise && ($urandom_range(0, 2) == 0);
        for (int k = 1; k <= tot + 1; k++) begin
            @(negedge clk);
            exp_cmd = '0;
            for (int n = 0; n < 4; n++) begin
                c = C_NOP;
                if (k <= len) begin
                    if (pend[n] && (k - 1 <= dly[n])) c = (typ == T_WR) ? C_WRS : C_RDS;
                end else if (k <= len + 1 + e && n == int'(cpu)) begin
                    c = (typ == T_WR) ? C_ENWR : C_ENRD;
                end
                exp_cmd[n*3 +: 3] = c;
            end
            total++;
            if (bus.cbus_cmd_array_o !== exp_cmd)
                $display("FAIL cmd k=%0d got=%h want=%h", k, bus.cbus_cmd_array_o, exp_cmd);
            else passed++;
            total++;
            if (bus.busy_o !== (k <= tot))
                $display("FAIL busy k=%0d got=%b want=%b", k, bus.busy_o, (k <= tot));
            else passed++;
            total++;
            if (bus.broad_fifo_rd_o !== (k == tot))
                $display("FAIL fifo_rd k=%0d got=%b want=%b", k, bus.broad_fifo_rd_o, (k == tot));
            else passed++;
            total++;
            if (bus.timeout_o !== (to && k == len + 1))
                $display("FAIL timeout k=%0d got=%b want=%b", k, bus.timeout_o, (to && k == len + 1));
            else passed++;
            total++;
            if (bus.id_err_o !== 1'b0 || bus.cur_broad_id_o !== id)
                $display("FAIL id k=%0d got err=%b id=%0d want err=0 id=%0d", k, bus.id_err_o,
                         bus.cur_broad_id_o, id);
            else passed++;
            // Inputs for cycle k; head and enables are junk while a broadcast is in flight.
            if (k <= tot) begin
                bus.fifo_status_empty_i = 1'($urandom_range(0, 1));
                bus.broad_snoop_type_i = 2'($urandom_range(0, 3));
                bus.broad_snoop_cpu_id_i = 2'($urandom_range(0, 3));
                bus.broad_snoop_id_i = 5'($urandom_range(0, 31));
                bus.cpu_enable_i = 4'($urandom_range(0, 15));
            end else begin
                bus.fifo_status_empty_i = 1'b1;
            end
            for (int n = 0; n < 4; n++) begin
                a = noise && ($urandom_range(0, 2) == 0);
                if (k <= len) begin
                    if (pend[n]) a = (k - 1 == dly[n]) || ((k - 1 > dly[n]) && a);
                end else if (k <= len + 1 + e) begin
                    if (n == int'(cpu)) a = (k == len + 1 + e);
                end
                bus.cbus_ack_array_i[n] = a;
            end
        end
        exp_pops++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (bus.cbus_cmd_array_o !== 12'h000 || bus.busy_o !== 1'b0 || bus.broad_fifo_rd_o !== 1'b0 ||
            bus.timeout_o !== 1'b0 || bus.id_err_o !== 1'b0 || bus.cur_broad_id_o !== 5'd0)
            $display("FAIL reset got cmd=%h busy=%b rd=%b to=%b err=%b id=%0d want all zero",
                     bus.cbus_cmd_array_o, bus.busy_o, bus.broad_fifo_rd_o, bus.timeout_o,
                     bus.id_err_o, bus.cur_broad_id_o);
        else passed++;
        total++;
        if (bus3.cbus_cmd_array_o !== 9'h000 || bus3.busy_o !== 1'b0 || bus3.id_err_o !== 1'b0)
            $display("FAIL reset3 got cmd=%h busy=%b err=%b want zero", bus3.cbus_cmd_array_o,
                     bus3.busy_o, bus3.id_err_o);
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_wr_all_ack();
        noise = 1'b0;
        dly[0] = 0; dly[1] = 0; dly[2] = 0; dly[3] = 0;
        bcast(T_WR, 2'd2, 5'd5, 4'hF, 2);
    endtask

    task automatic test_staggered_rd();
        dly[0] = 0; dly[1] = 0; dly[2] = 0; dly[3] = 3;
        bcast(T_RD, 2'd2, 5'd12, 4'b1101, 1);
    endtask

    task automatic test_no_snoop();
        bcast(T_WR, 2'd0, 5'd21, 4'b0001, 0);
    endtask

    task automatic test_timeout();
        dly[0] = 0; dly[1] = 100; dly[2] = 1; dly[3] = 2;
        bcast(T_RD, 2'd0, 5'd30, 4'hF, 1);
    endtask

    task automatic test_id_err();
        bus3.broad_snoop_type_i = T_WR;
        bus3.broad_snoop_cpu_id_i = 2'd3;
        bus3.broad_snoop_id_i = 5'd7;
        bus3.fifo_status_empty_i = 1'b0;
        @(negedge clk);
        total++;
        if (bus3.id_err_o !== 1'b1 || bus3.broad_fifo_rd_o !== 1'b1 || bus3.busy_o !== 1'b1 ||
            bus3.cbus_cmd_array_o !== 9'h000)
            $display("FAIL id_err_pulse got err=%b rd=%b busy=%b cmd=%h want 1 1 1 000",
                     bus3.id_err_o, bus3.broad_fifo_rd_o, bus3.busy_o, bus3.cbus_cmd_array_o);
        else passed++;
        bus3.fifo_status_empty_i = 1'b1;
        @(negedge clk);
        total++;
        if (bus3.id_err_o !== 1'b0 || bus3.broad_fifo_rd_o !== 1'b0 || bus3.busy_o !== 1'b0 ||
            bus3.cbus_cmd_array_o !== 9'h000 || bus3.cur_broad_id_o !== 5'd0)
            $display("FAIL id_err_after got err=%b rd=%b busy=%b cmd=%h id=%0d want 0 0 0 000 0",
                     bus3.id_err_o, bus3.broad_fifo_rd_o, bus3.busy_o, bus3.cbus_cmd_array_o,
                     bus3.cur_broad_id_o);
        else passed++;
    endtask

    task automatic test_reset_mid();
        noise = 1'b0;
        bus.fifo_status_empty_i = 1'b0;
        bus.broad_snoop_type_i = T_RD;
        bus.broad_snoop_cpu_id_i = 2'd1;
        bus.broad_snoop_id_i = 5'd9;
        bus.cpu_enable_i = 4'hF;
        bus.cbus_ack_array_i = 4'b0000;
        @(negedge clk);
        total++;
        if (bus.cbus_cmd_array_o !== {C_RDS, C_RDS, C_NOP, C_RDS})
            $display("FAIL rstmid_snoop got=%h want=%h", bus.cbus_cmd_array_o,
                     {C_RDS, C_RDS, C_NOP, C_RDS});
        else passed++;
        bus.cbus_ack_array_i = 4'b1101;
        @(negedge clk);
        total++;
        if (bus.cbus_cmd_array_o !== {C_NOP, C_NOP, C_ENRD, C_NOP})
            $display("FAIL rstmid_en got=%h want=%h", bus.cbus_cmd_array_o,
                     {C_NOP, C_NOP, C_ENRD, C_NOP});
        else passed++;
        bus.cbus_ack_array_i = 4'b0000;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (bus.cbus_cmd_array_o !== 12'h000 || bus.busy_o !== 1'b0 || bus.broad_fifo_rd_o !== 1'b0 ||
            bus.cur_broad_id_o !== 5'd0)
            $display("FAIL rstmid_async got cmd=%h busy=%b rd=%b id=%0d want 000 0 0 0",
                     bus.cbus_cmd_array_o, bus.busy_o, bus.broad_fifo_rd_o, bus.cur_broad_id_o);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        dly[0] = 0; dly[1] = 0; dly[2] = 0; dly[3] = 0;
        bcast(T_RD, 2'd1, 5'd9, 4'hF, 1);
    endtask

    task automatic test_back_to_back();
        logic [3:0] en;
        int e;
        noise = 1'b1;
        for (int i = 0; i < 40; i++) begin
            for (int n = 0; n < 4; n++)
                dly[n] = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 6));
            en = 4'($urandom_range(0, 15));
            e = int'($urandom_range(0, 4));
            bcast(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                  en, e);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.cbus_ack_array_i = '0;
        bus.cpu_enable_i = 4'hF;
        bus.fifo_status_empty_i = 1'b1;
        bus.broad_snoop_type_i = '0;
        bus.broad_snoop_cpu_id_i = '0;
        bus.broad_snoop_id_i = '0;
        bus3.cbus_ack_array_i = '0;
        bus3.cpu_enable_i = 3'b111;
        bus3.fifo_status_empty_i = 1'b1;
        bus3.broad_snoop_type_i = '0;
        bus3.broad_snoop_cpu_id_i = '0;
        bus3.broad_snoop_id_i = '0;
        test_reset();
        test_wr_all_ack();
        test_staggered_rd();
        test_no_snoop();
        test_timeout();
        test_id_err();
        test_reset_mid();
        test_back_to_back();
        @(negedge clk);
        total++;
        if (pops_seen !== exp_pops)
            $display("FAIL pop_count got=%0d want=%0d", pops_seen, exp_pops);
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mesi_isc_broad_cntl_mp.md
MESI_ISC_BROAD_CNTL_MP -- requirements
Module: mesi_isc_broad_cntl_mp

Interface
REQ-001 SHALL have parameter CPU_COUNT, default 4, number of coherence-bus ports (legal range 2..16).
REQ-002 SHALL have parameter CBUS_CMD_WIDTH, default 3, width of one per-port command field.
REQ-003 SHALL have parameter BROAD_TYPE_WIDTH, default 2, broadcast type width.
REQ-004 SHALL have parameter BROAD_ID_WIDTH, default 5, broadcast ID width.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 256, max snoop-phase cycles; 0 disables timeout.
REQ-006 SHALL derive localparam CPU_ID_WIDTH = max(1, clog2(CPU_COUNT)).
REQ-007 clk  input  1  system clock, all state on rising edge.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 cbus_ack_array_i  input  CPU_COUNT  per-port acknowledge, bit n = port n.
REQ-010 cpu_enable_i  input  CPU_COUNT  per-port present mask; disabled ports are never snooped.
REQ-011 fifo_status_empty_i  input  1  broadcast FIFO empty.
REQ-012 broad_snoop_type_i  input  BROAD_TYPE_WIDTH  type of FIFO head entry.
REQ-013 broad_snoop_cpu_id_i  input  CPU_ID_WIDTH  initiator of FIFO head entry.
REQ-014 broad_snoop_id_i  input  BROAD_ID_WIDTH  ID of FIFO head entry.
REQ-015 cbus_cmd_array_o  output  CPU_COUNT*CBUS_CMD_WIDTH  per-port command, port n in bits [(n+1)*W-1 : n*W].
REQ-016 broad_fifo_rd_o  output  1  one-cycle pop strobe to broadcast FIFO.
REQ-017 busy_o  output  1  high in any state other than IDLE.
REQ-018 cur_broad_id_o  output  BROAD_ID_WIDTH  latched ID of broadcast in progress.
REQ-019 timeout_o  output  1  one-cycle pulse when snoop phase times out.
REQ-020 id_err_o  output  1  one-cycle pulse when head entry has initiator ID >= CPU_COUNT.

Function
REQ-021 SHALL implement FSM states IDLE, SNOOP, EN_ACCESS, POP; command encodings SHALL be the MESI_ISC_CBUS_CMD_* values of mesi_isc_define.sv.
REQ-022 IDLE, fifo_status_empty_i=0, cpu_id<CPU_COUNT: latch type/cpu_id/id; snoop_pending = cpu_enable_i with initiator bit cleared; next state SNOOP, or EN_ACCESS if snoop_pending==0.
REQ-023 IDLE, fifo_status_empty_i=0, cpu_id>=CPU_COUNT: pulse id_err_o, go to POP (entry discarded, no bus commands).
REQ-024 Commands SHALL be decoded from latched type only; FIFO head changes during a broadcast SHALL have no effect.
REQ-025 SNOOP: port n with snoop_pending[n]=1 drives WR_SNOOP if latched type==MESI_ISC_BREQ_TYPE_WR else RD_SNOOP; all other ports drive NOP.
REQ-026 SNOOP: each edge clears snoop_pending & cbus_ack_array_i; cleared port drives NOP from the next cycle; acks on non-pending ports are ignored.
REQ-027 SNOOP: when snoop_pending becomes 0, next state EN_ACCESS (no idle cycle between).
REQ-028 SNOOP: cycle counter starts at 0 on entry; at TIMEOUT_CYCLES (if nonzero) with bits still pending, clear snoop_pending, pulse timeout_o, go EN_ACCESS.
REQ-029 EN_ACCESS: initiator port drives EN_WR (type WR) or EN_RD (otherwise), others NOP; on initiator ack go POP.
REQ-030 POP: broad_fifo_rd_o=1 for exactly one cycle, all commands NOP, next state IDLE.
REQ-031 Back-to-back: IDLE after POP SHALL re-sample FIFO status, giving a 1-cycle minimum gap between broadcasts.
REQ-032 busy_o and cur_broad_id_o SHALL be registered; cur_broad_id_o holds its value in IDLE.

Reset
REQ-033 On rst: state IDLE, snoop_pending=0, counter=0, all commands NOP, broad_fifo_rd_o=0, busy_o=0, timeout_o=0, id_err_o=0, cur_broad_id_o=0.
REQ-034 Reset mid-broadcast SHALL abandon it without popping the FIFO; the entry is replayed after reset release.

Verification
REQ-035 CPU_COUNT=4, enable=4'hF, head {type WR, cpu 2, id 5}; ack ports 0,1,3 one cycle after SNOOP entry -> ports 0,1,3 WR_SNOOP for 1 cycle, port 2 EN_WR until ack, then broad_fifo_rd_o one pulse, cur_broad_id_o=5.
REQ-036 Staggered acks (port 0 at cycle 1, port 3 at cycle 4), type RD -> each port returns to NOP the cycle after its ack; EN_RD only after last ack.
REQ-037 enable=4'b0001, cpu 0 -> no snoop commands, EN access issued the cycle after IDLE sample.
REQ-038 TIMEOUT_CYCLES=8, port 1 never acks -> timeout_o pulses once, EN access issued to initiator, FIFO popped after initiator ack.
REQ-039 CPU_COUNT=3, head cpu_id=3 -> id_err_o pulse, broad_fifo_rd_o pulse, all commands NOP throughout.
REQ-040 rst asserted during EN_ACCESS -> outputs reset asynchronously, no pop; same entry broadcast again after release.
